// File: rtl/vga_seq_pkg.sv
// Shared command/response byte codes, FSM state encoding and ASCII hex helpers
// for the VGA pattern sequencer.
package vga_seq_pkg;

    localparam logic [7:0] CMD_DWELL    = 8'h44;
    localparam logic [7:0] CMD_AUTO_ON  = 8'h47;
    localparam logic [7:0] CMD_AUTO_OFF = 8'h48;
    localparam logic [7:0] CMD_STATUS   = 8'h53;

    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_NAK = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GET_ARG = 2'd1,
        ST_RESP    = 2'd2
    } seq_state_t;

    // Digits '0'..'9' and lowercase 'a'..'f'; uppercase letters are commands.
    function automatic logic is_hex_cmd(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) || ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    function automatic logic [3:0] hex_val(input logic letter, input logic [3:0] nib);
        return letter ? (nib + 4'd9) : nib;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

endpackage

// File: rtl/vga_frame_timer.sv
// Frame tick from a falling edge of the registered VSync, plus the auto-cycle
// dwell counter that flags when the pattern should advance on that tick.
module vga_frame_timer (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_VSync,
    input  logic       i_Auto,
    input  logic       i_Clr,
    input  logic [7:0] i_Dwell,
    output logic       o_Tick,
    output logic       o_Advance
);
    logic       vsync_q, vsync_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        vsync_d   = i_VSync;
        o_Tick    = vsync_q & ~i_VSync;
        o_Advance = o_Tick & i_Auto & (cnt_q == (i_Dwell - 8'd1));
        cnt_d     = cnt_q;
        if (o_Advance)
            cnt_d = 8'd0;
        else if (o_Tick && i_Auto)
            cnt_d = cnt_q + 8'd1;
        // A dwell change or auto entry restarts the interval even on a tick cycle.
        if (i_Clr)
            cnt_d = 8'd0;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            vsync_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            vsync_q <= vsync_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// UART-commanded test-pattern sequencer: manual select, auto-cycle with dwell, ACK/NAK replies.
// Define VGA_SEQ_STATUS_EN to make 'S' reply with the current pattern as an ASCII hex digit.
module vga_pattern_sequencer
    import vga_seq_pkg::*;
#(
    parameter int NUM_PATTERNS = 8,
    parameter int RESET_DWELL  = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_VSync,
    input  logic       i_TX_Active,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    output logic [3:0] o_Pattern,
    output logic       o_Auto
);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_PATTERNS - 1);
    localparam logic [4:0] NUM_PAT5  = 5'(NUM_PATTERNS);
    localparam logic [7:0] DWELL_RST = 8'(RESET_DWELL);

    seq_state_t state_q, state_d;
    logic [3:0] pattern_q, pattern_d;
    logic       auto_q, auto_d;
    logic [7:0] dwell_q, dwell_d;
    logic       pend_vld_q, pend_vld_d;
    logic [3:0] pend_idx_q, pend_idx_d;
    logic       tx_dv_q, tx_dv_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       cnt_clr, tick, advance;
    logic [3:0] sel_idx;

    vga_frame_timer u_timer (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_VSync   (i_VSync),
        .i_Auto    (auto_q),
        .i_Clr     (cnt_clr),
        .i_Dwell   (dwell_q),
        .o_Tick    (tick),
        .o_Advance (advance)
    );

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        auto_d     = auto_q;
        dwell_d    = dwell_q;
        pend_vld_d = pend_vld_q;
        pend_idx_d = pend_idx_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        cnt_clr    = 1'b0;
        sel_idx    = hex_val(i_RX_Byte[6], i_RX_Byte[3:0]);

        // Tick works on pre-command state; a same-cycle select re-arms pending below.
        if (tick) begin
            if (pend_vld_q) begin
                pattern_d  = pend_idx_q;
                pend_vld_d = 1'b0;
            end else if (advance) begin
                pattern_d = (pattern_q == LAST_IDX) ? 4'd0 : pattern_q + 4'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_RX_DV) begin
                    state_d   = ST_RESP;
                    tx_byte_d = RSP_NAK;
                    if (is_hex_cmd(i_RX_Byte)) begin
                        if ({1'b0, sel_idx} < NUM_PAT5) begin
                            pend_idx_d = sel_idx;
                            pend_vld_d = 1'b1;
                            auto_d     = 1'b0;
                            tx_byte_d  = RSP_ACK;
                        end
                    end else begin
                        case (i_RX_Byte)
                            CMD_AUTO_ON: begin
                                auto_d    = 1'b1;
                                cnt_clr   = 1'b1;
                                tx_byte_d = RSP_ACK;
                            end
                            CMD_AUTO_OFF: begin
                                auto_d    = 1'b0;
                                tx_byte_d = RSP_ACK;
                            end
                            CMD_DWELL: begin
                                state_d   = ST_GET_ARG;
                                tx_byte_d = tx_byte_q;
                            end
`ifdef VGA_SEQ_STATUS_EN
                            CMD_STATUS: tx_byte_d = hex_ascii(pattern_q);
`endif
                            default: ;
                        endcase
                    end
                end
            end
            ST_GET_ARG: begin
                if (i_RX_DV) begin
                    dwell_d   = (i_RX_Byte == 8'd0) ? 8'd1 : i_RX_Byte;
                    cnt_clr   = 1'b1;
                    tx_byte_d = RSP_ACK;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!i_TX_Active) begin
                    tx_dv_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            pattern_q  <= 4'd0;
            auto_q     <= 1'b0;
            dwell_q    <= DWELL_RST;
            pend_vld_q <= 1'b0;
            pend_idx_q <= 4'd0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            auto_q     <= auto_d;
            dwell_q    <= dwell_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign o_TX_DV   = tx_dv_q;
    assign o_TX_Byte = tx_byte_q;
    assign o_Pattern = pattern_q;
    assign o_Auto    = auto_q;

endmodule
